// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM status codes and the memory arbiter
// state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DACC  = 2'd1,
        IACC  = 2'd2,
        FAULT = 2'd3
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the CPU-side request/response signals and the RAM-side strobes
// and status around the memory arbiter. The arbiter is the master (it drives
// the RAM); the CPU caches and RAM together form the slave side.
interface memory_arbiter_if;
    import cpu_types_pkg::*;

    // CPU side
    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      ihit;
    logic      dhit;
    word_t     iload;
    word_t     dload;
    logic      fault;

    // RAM side
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    ramstate_t ramstate;
    word_t     ramload;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        output ihit, dhit, iload, dload, fault, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        input  ihit, dhit, iload, dload, fault, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/access_timer.sv
// Wait-cycle counter for one RAM access. Cleared while the arbiter is idle,
// counts every enabled cycle and saturates at the limit. 'expired' flags the
// cycle whose increment makes the count reach the limit, so the caller can
// leave the access on that same edge.
module access_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up to the limit and hold there.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != limit)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (({1'b0, cnt_q} + (W+1)'(1)) >= {1'b0, limit});

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates a single RAM port between instruction fetch and data access.
// Data requests win; each access waits for ACCESS from the RAM, pulses the
// matching hit for one cycle and returns to IDLE to re-arbitrate. A RAM
// ERROR or too many wait cycles lock the arbiter in FAULT until reset.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             nRST,
    memory_arbiter_if.master bus
);

    localparam int                CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT);

    arb_state_t state_q, state_d;
    word_t      addr_q,  addr_d;
    word_t      store_q, store_d;
    logic       wen_q,   wen_d;
    logic       ihit_q,  ihit_d;
    logic       dhit_q,  dhit_d;
    word_t      iload_q, iload_d;
    word_t      dload_q, dload_d;
    logic       fault_q, fault_d;

    logic       timer_clear;
    logic       timer_en;
    logic       timer_expired;
    logic       req_live;

    access_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk     (CLK),
        .rst_n   (nRST),
        .clear   (timer_clear),
        .enable  (timer_en),
        .limit   (LIMIT),
        .expired (timer_expired)
    );

    // Next-state, capture and hit/fault decisions for the arbiter.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        store_d     = store_q;
        wen_d       = wen_q;
        ihit_d      = 1'b0;
        dhit_d      = 1'b0;
        iload_d     = iload_q;
        dload_d     = dload_q;
        fault_d     = fault_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        req_live    = (state_q == DACC) ? (bus.dREN || bus.dWEN) : bus.iREN;

        case (state_q)
            IDLE: begin
                timer_clear = 1'b1;
                if (bus.dREN || bus.dWEN) begin
                    state_d = DACC;
                    addr_d  = bus.daddr;
                    store_d = bus.dstore;
                    wen_d   = bus.dWEN;
                end else if (bus.iREN) begin
                    state_d = IACC;
                    addr_d  = bus.iaddr;
                    store_d = bus.dstore;
                    wen_d   = 1'b0;
                end
            end

            DACC, IACC: begin
                timer_en = (bus.ramstate != ACCESS);
                if (bus.ramstate == ERROR) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                end else if (bus.ramstate == ACCESS) begin
                    state_d = IDLE;
                    if (state_q == DACC) begin
                        dhit_d = 1'b1;
                        // A write completes with a hit but returns no data.
                        if (!wen_q) begin
                            dload_d = bus.ramload;
                        end
                    end else begin
                        ihit_d  = 1'b1;
                        iload_d = bus.ramload;
                    end
                end else if (!req_live) begin
                    state_d = IDLE;
                end else if (timer_expired) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                end
            end

            FAULT: begin
                state_d = FAULT;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All arbiter state and registered outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            store_q <= '0;
            wen_q   <= 1'b0;
            ihit_q  <= 1'b0;
            dhit_q  <= 1'b0;
            iload_q <= '0;
            dload_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            wen_q   <= wen_d;
            ihit_q  <= ihit_d;
            dhit_q  <= dhit_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
            fault_q <= fault_d;
        end
    end

    // RAM strobes are decoded purely from registered state.
    assign bus.ramREN   = (state_q == IACC) || ((state_q == DACC) && !wen_q);
    assign bus.ramWEN   = (state_q == DACC) && wen_q;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;
    assign bus.ihit     = ihit_q;
    assign bus.dhit     = dhit_q;
    assign bus.iload    = iload_q;
    assign bus.dload    = dload_q;
    assign bus.fault    = fault_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: stimulus pushes the expected hit
// (kind and returned word) into a queue, a negedge monitor pops and checks
// each hit the DUT presents; direct checks cover strobes, addresses, reset
// and fault behaviour.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    typedef struct {
        bit    is_d;
        word_t data;
    } exp_t;

    logic CLK;
    logic nRST;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    memory_arbiter_if bus ();

    memory_arbiter #(
        .TIMEOUT (15)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.master)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input bit is_d, input word_t data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ramREN"},   {31'd0, bus.ramREN}, 32'd0);
        chk({tag, "_ramWEN"},   {31'd0, bus.ramWEN}, 32'd0);
        chk({tag, "_ramaddr"},  bus.ramaddr,  32'd0);
        chk({tag, "_ramstore"}, bus.ramstore, 32'd0);
        chk({tag, "_hits"},     {30'd0, bus.ihit, bus.dhit}, 32'd0);
        chk({tag, "_iload"},    bus.iload,    32'd0);
        chk({tag, "_dload"},    bus.dload,    32'd0);
        chk({tag, "_fault"},    {31'd0, bus.fault}, 32'd0);
    endtask

    // Scoreboard monitor: every hit must match the oldest expected response.
    always @(negedge CLK) begin
        exp_t e;
        if (nRST && (bus.ihit || bus.dhit)) begin
            chk("hit_exclusive", {31'd0, bus.ihit & bus.dhit}, 32'd0);
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_hit: ihit=%b dhit=%b, expected no hit at %0t",
                         bus.ihit, bus.dhit, $time);
            end else begin
                e = sb.pop_front();
                chk("hit_kind", {31'd0, bus.dhit}, {31'd0, e.is_d});
                chk("hit_data", e.is_d ? bus.dload : bus.iload, e.data);
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        nRST        = 1'b0;
        bus.iREN    = 1'b0;
        bus.iaddr   = '0;
        bus.dREN    = 1'b0;
        bus.dWEN    = 1'b0;
        bus.daddr   = '0;
        bus.dstore  = '0;
        bus.ramstate = FREE;
        bus.ramload = '0;
        #1;
        check_all_zero("reset");
        #19 nRST = 1'b1;
        tick();

        // Instruction fetch, two BUSY cycles then ACCESS: hit at cycle 4.
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h0000_0040;
        tick();                                    // edge 1 -> IACC
        chk("i_ramREN", {31'd0, bus.ramREN}, 32'd1);
        chk("i_ramaddr", bus.ramaddr, 32'h0000_0040);
        bus.ramstate = BUSY;
        tick();                                    // edge 2
        chk("i_nohit_busy", {31'd0, bus.ihit}, 32'd0);
        tick();                                    // edge 3
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h8C22_0004;
        push_exp(1'b0, 32'h8C22_0004);
        tick();                                    // edge 4 -> hit
        chk("i_hit_c4", {31'd0, bus.ihit}, 32'd1);
        chk("i_iload", bus.iload, 32'h8C22_0004);
        bus.iREN     = 1'b0;
        bus.ramstate = FREE;
        tick();
        chk("i_hit_one_cycle", {31'd0, bus.ihit}, 32'd0);
        chk("i_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);

        // Simultaneous data and fetch requests: data first.
        bus.dREN  = 1'b1;
        bus.daddr = 32'h0000_0100;
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h0000_0200;
        tick();
        chk("prio_ramaddr_d", bus.ramaddr, 32'h0000_0100);
        chk("prio_ramREN_d", {31'd0, bus.ramREN}, 32'd1);
        chk("prio_ramWEN_d", {31'd0, bus.ramWEN}, 32'd0);
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h1111_2222;
        push_exp(1'b1, 32'h1111_2222);
        tick();
        chk("prio_dhit", {31'd0, bus.dhit}, 32'd1);
        chk("prio_dload", bus.dload, 32'h1111_2222);
        bus.dREN     = 1'b0;
        bus.ramstate = FREE;
        tick();
        chk("prio_ramaddr_i", bus.ramaddr, 32'h0000_0200);
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h3333_4444;
        push_exp(1'b0, 32'h3333_4444);
        tick();
        chk("prio_ihit", {31'd0, bus.ihit}, 32'd1);
        bus.iREN     = 1'b0;
        bus.ramstate = FREE;
        tick();

        // Write (dREN and dWEN both high): write wins, dload unchanged.
        bus.dREN   = 1'b1;
        bus.dWEN   = 1'b1;
        bus.daddr  = 32'h0000_0080;
        bus.dstore = 32'hDEAD_BEEF;
        tick();
        chk("wr_ramWEN", {31'd0, bus.ramWEN}, 32'd1);
        chk("wr_ramREN", {31'd0, bus.ramREN}, 32'd0);
        chk("wr_ramstore", bus.ramstore, 32'hDEAD_BEEF);
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h5555_5555;
        push_exp(1'b1, 32'h1111_2222);
        tick();
        chk("wr_dhit", {31'd0, bus.dhit}, 32'd1);
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.ramstate = FREE;
        tick();

        // Data request dropped after one BUSY cycle, then a fetch.
        bus.dREN  = 1'b1;
        bus.daddr = 32'h0000_0300;
        tick();
        bus.ramstate = BUSY;
        tick();
        bus.dREN = 1'b0;
        tick();
        chk("abort_ramREN", {31'd0, bus.ramREN}, 32'd0);
        chk("abort_nodhit", {31'd0, bus.dhit}, 32'd0);
        bus.ramstate = FREE;
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h0000_0044;
        tick();
        chk("abort_next_ramaddr", bus.ramaddr, 32'h0000_0044);
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h6666_6666;
        push_exp(1'b0, 32'h6666_6666);
        tick();
        chk("abort_next_ihit", {31'd0, bus.ihit}, 32'd1);
        bus.iREN     = 1'b0;
        bus.ramstate = FREE;
        tick();

        // Reset pulsed during a data access.
        bus.dREN  = 1'b1;
        bus.daddr = 32'h0000_0500;
        tick();
        bus.ramstate = BUSY;
        #2 nRST = 1'b0;
        #1;
        check_all_zero("midrst");
        bus.dREN     = 1'b0;
        bus.ramstate = ACCESS;
        #3 nRST = 1'b1;
        tick();
        tick();
        chk("midrst_nodhit", {31'd0, bus.dhit}, 32'd0);
        chk("midrst_ramREN", {31'd0, bus.ramREN}, 32'd0);
        bus.ramstate = FREE;
        tick();

        // Timeout: BUSY for 15 cycles faults at cycle 16.
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h0000_0070;
        tick();                                    // edge 1 -> IACC
        bus.ramstate = BUSY;
        for (int k = 2; k <= 15; k++) begin
            tick();
        end
        chk("to_nofault_c15", {31'd0, bus.fault}, 32'd0);
        chk("to_ramREN_c15", {31'd0, bus.ramREN}, 32'd1);
        tick();                                    // edge 16
        chk("to_fault_c16", {31'd0, bus.fault}, 32'd1);
        chk("to_ramREN_c16", {31'd0, bus.ramREN}, 32'd0);
        bus.ramstate = ACCESS;
        bus.dREN     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
        end
        chk("to_fault_sticky", {31'd0, bus.fault}, 32'd1);
        chk("to_strobes_low", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
        chk("to_nohits", {30'd0, bus.ihit, bus.dhit}, 32'd0);
        bus.dREN     = 1'b0;
        bus.iREN     = 1'b0;
        bus.ramstate = FREE;
        #2 nRST = 1'b0;
        #1;
        chk("to_reset_clears", {31'd0, bus.fault}, 32'd0);
        #3 nRST = 1'b1;
        tick();

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
